// File: rtl/rv_pkg.sv
// Shared RV32I load/store width codes, LSU state encoding and the LSU timeout default.
package rv_pkg;

   localparam int unsigned TimeoutCyclesDefault = 16;

   localparam logic [2:0] Funct3B  = 3'b000;
   localparam logic [2:0] Funct3H  = 3'b001;
   localparam logic [2:0] Funct3W  = 3'b010;
   localparam logic [2:0] Funct3Bu = 3'b100;
   localparam logic [2:0] Funct3Hu = 3'b101;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StResp = 2'b10
   } lsu_state_e;

   // Unsigned widths only exist for loads.
   function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
      case (f3)
         Funct3B, Funct3H, Funct3W: return 1'b0;
         Funct3Bu, Funct3Hu:        return we;
         default:                   return 1'b1;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store path replicates data and builds enables, load path
// selects the addressed lane and sign/zero-extends it.
module lsu_align import rv_pkg::*; #(
   parameter bit LoadPath = 1'b0
) (
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [3:0]  be_o
);

   if (LoadPath) begin : g_load
      logic [15:0] lane;
      assign lane = 16'(data_i >> {offset_i, 3'b000});

      always_comb begin
         be_o = 4'b1111;
         case (funct3_i)
            Funct3B:  data_o = {{24{lane[7]}}, lane[7:0]};
            Funct3H:  data_o = {{16{lane[15]}}, lane};
            Funct3Bu: data_o = {24'h0, lane[7:0]};
            Funct3Hu: data_o = {16'h0, lane};
            default:  data_o = data_i;
         endcase
      end
   end else begin : g_store
      always_comb begin
         case (funct3_i)
            Funct3B: begin
               data_o = {4{data_i[7:0]}};
               be_o   = 4'b0001 << offset_i;
            end
            Funct3H: begin
               data_o = {2{data_i[15:0]}};
               be_o   = 4'b0011 << offset_i;
            end
            default: begin
               data_o = data_i;
               be_o   = 4'b1111;
            end
         endcase
      end
   end

endmodule

// File: rtl/lsu.sv
// Single-outstanding RV32I load/store unit with memory timeout.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
module lsu import rv_pkg::*; #(
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

   lsu_state_e     state_q, state_d;
   logic           req_ready_q, req_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_err_q, rsp_err_d;
   logic [31:0]    rsp_rdata_q, rsp_rdata_d;
   logic           mem_req_q, mem_req_d;
   logic           mem_we_q, mem_we_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
   logic [3:0]     mem_be_q, mem_be_d;
   logic           we_q, we_d;
   logic [2:0]     funct3_q, funct3_d;
   logic [1:0]     off_q, off_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic        mis_err;
   logic [1:0]  eff_off;
   logic [31:0] st_data, ld_data;
   logic [3:0]  st_be, ld_be;

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_err = misaligned(req_funct3, req_addr[1:0]);
   assign eff_off = req_addr[1:0];
`else
   assign mis_err = 1'b0;
   // Halfwords drop bit 0, words drop both bits; bytes are never misaligned.
   assign eff_off = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} :
                    (req_funct3[1:0] == 2'b10) ? 2'b00 : req_addr[1:0];
`endif

   lsu_align #(.LoadPath(1'b0)) u_align_st (
      .funct3_i (req_funct3),
      .offset_i (eff_off),
      .data_i   (req_wdata),
      .data_o   (st_data),
      .be_o     (st_be)
   );

   lsu_align #(.LoadPath(1'b1)) u_align_ld (
      .funct3_i (funct3_q),
      .offset_i (off_q),
      .data_i   (mem_rdata),
      .data_o   (ld_data),
      .be_o     (ld_be)
   );

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               req_ready_d = 1'b0;
               we_d        = req_we;
               funct3_d    = req_funct3;
               off_d       = eff_off;
               cnt_d       = '0;
               if (funct3_illegal(req_we, req_funct3) || mis_err) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
               end else begin
                  state_d     = StWait;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = req_we ? st_be : ld_be;
                  mem_wdata_d = req_we ? st_data : '0;
               end
            end
         end
         StWait: begin
            if (mem_ack) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = we_q ? '0 : ld_data;
            end else if (cnt_q == CntLimit) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
            mem_req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed corner cases then random transactions against a byte-level model.
module tb_lsu;

   localparam int T = 16;
   localparam int Never = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int total = 0;
   int bad = 0;

   lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          err;
      bit          access;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-level model; lat = cycles from the acceptance cycle to the rsp_valid cycle.
   function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] wd, input bit [31:0] rd, input int ackd);
      exp_t e;
      int size;
      int off;
      bit mis;
      bit [31:0] ea;
      longint v;
      e.err = 1'b1; e.access = 1'b0; e.addr = 32'h0; e.be = 4'h0;
      e.wdata = 32'h0; e.rdata = 32'h0; e.lat = 1;
      if (f3 == 3 || f3 >= 6 || (we && f3 >= 4)) return e;
      size = 1 << f3[1:0];
      mis = (addr % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (mis) return e;
`endif
      ea = addr - (addr % size);
      off = ea % 4;
      e.access = 1'b1;
      e.addr = addr - (addr % 4);
      e.be = we ? 4'(((1 << size) - 1) << off) : 4'hf;
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      if (ackd > T) begin
         e.lat = T + 2;
         return e;
      end
      e.err = 1'b0;
      e.lat = ackd + 2;
      if (!we) begin
         v = (64'(rd) >> (8 * off)) % (64'd1 << (8 * size));
         if (f3[2] == 1'b0 && size < 4 && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
         e.rdata = 32'(v);
      end
      return e;
   endfunction

   // ackd: index of the WAIT cycle in which mem_ack is pulsed (0 = first).
   task automatic do_txn(input bit sync, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rd, input int ackd,
                         input string tag);
      exp_t e;
      int cyc;
      bit seen;
      e = model(we, f3, addr, wd, rd, ackd);
      if (sync) @(negedge clk);
      check({tag, "/ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, "/mem_req"}, 32'(mem_req), 32'(e.access));
      if (e.access) begin
         check({tag, "/mem_we"}, 32'(mem_we), 32'(we));
         check({tag, "/mem_addr"}, mem_addr, e.addr);
         check({tag, "/mem_be"}, 32'(mem_be), 32'(e.be));
         if (we) check({tag, "/mem_wdata"}, mem_wdata, e.wdata);
      end
      seen = 1'b0;
      cyc = 1;
      while (cyc <= T + 4 && !seen) begin
         if (rsp_valid) begin
            seen = 1'b1;
         end else begin
            mem_ack = ((cyc - 1) == ackd);
            mem_rdata = mem_ack ? rd : $urandom;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
         end
      end
      check({tag, "/latency"}, seen ? 32'(cyc) : 32'd0, 32'(e.lat));
      if (seen) begin
         check({tag, "/rsp_err"}, 32'(rsp_err), 32'(e.err));
         check({tag, "/rsp_rdata"}, rsp_rdata, e.rdata);
         check({tag, "/resp_mem_req"}, 32'(mem_req), 32'd0);
         check({tag, "/resp_ready"}, 32'(req_ready), 32'd0);
         // A stray ack during RESP must be ignored.
         mem_ack = 1'($urandom % 2);
         @(posedge clk); #1;
         mem_ack = 1'b0;
         check({tag, "/pulse_end"}, 32'(rsp_valid), 32'd0);
         check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/ready"}, 32'(req_ready), 32'd1);
      check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "/rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
      check({tag, "/mem_req"}, 32'(mem_req), 32'd0);
      check({tag, "/mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "/mem_be"}, 32'(mem_be), 32'd0);
      check({tag, "/mem_addr"}, mem_addr, 32'd0);
      check({tag, "/mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      bit we;
      bit [2:0] f3;
      int ackd;
      int r;

      #1 rst = 1'b0;
      #2 check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      // First edge after release must accept.
      do_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0, "sh_102");
      do_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, "lb_103");
      do_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, "lbu_103");
      do_txn(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h1234ABCD, 0, "lh_101");
      do_txn(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h9876ABCD, 2, "lhu_102");
      do_txn(1'b1, 1'b1, 3'b010, 32'h203, 32'hCAFEF00D, 32'h0, 0, "sw_203");
      do_txn(1'b1, 1'b1, 3'b000, 32'h2, 32'h12345678, 32'h0, 0, "sb_2");
      do_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, Never, "lw_timeout");
      do_txn(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'hA5A5_5A5A, T, "lw_ack_at_limit");
      do_txn(1'b1, 1'b0, 3'b010, 32'h408, 32'h0, 32'h1111_2222, T + 1, "lw_ack_late");
      do_txn(1'b1, 1'b0, 3'b011, 32'h500, 32'h0, 32'h0, 0, "illegal_011");
      do_txn(1'b1, 1'b0, 3'b111, 32'h500, 32'h0, 32'h0, 0, "illegal_111");

      // Reset in the middle of WAIT, then a late ack.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rst_wait/mem_req", 32'(mem_req), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1 check_reset_outputs("rst_wait");
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      rst = 1'b1;
      mem_ack = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         check("rst_wait/no_rsp", 32'(rsp_valid), 32'd0);
         check("rst_wait/ready", 32'(req_ready), 32'd1);
      end

      // Illegal store held valid back-to-back with a legal one.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b100; req_addr = 32'h300;
      req_wdata = 32'h0;
      @(posedge clk); #1;
      check("b2b/rsp_valid", 32'(rsp_valid), 32'd1);
      check("b2b/rsp_err", 32'(rsp_err), 32'd1);
      check("b2b/no_mem", 32'(mem_req), 32'd0);
      check("b2b/busy", 32'(req_ready), 32'd0);
      req_funct3 = 3'b010; req_addr = 32'h704; req_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      check("b2b/resp_done", 32'(rsp_valid), 32'd0);
      check("b2b/not_taken", 32'(mem_req), 32'd0);
      check("b2b/ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("b2b/second_req", 32'(mem_req), 32'd1);
      check("b2b/second_addr", mem_addr, 32'h704);
      check("b2b/second_wdata", mem_wdata, 32'h0BADF00D);
      @(negedge clk);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("b2b/second_rsp", 32'(rsp_valid), 32'd1);
      check("b2b/second_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 80; n++) begin
         we = 1'($urandom % 2);
         f3 = 3'($urandom % 8);
         r = int'($urandom % 10);
         if (r < 7) ackd = int'($urandom % 4);
         else if (r == 7) ackd = T;
         else if (r == 8) ackd = T - 1;
         else ackd = Never;
         do_txn(1'b1, we, f3, $urandom, $urandom, $urandom, ackd, $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of cycles lsu waits for mem_ack before aborting with an error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a load/store.
REQ-005 req_ready  output  1  lsu accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle pulse carrying the result.
REQ-011 rsp_rdata  output  32  load result, extended per funct3; 0 for stores.
REQ-012 rsp_err  output  1  misaligned, illegal funct3, or timeout; qualified by rsp_valid.
REQ-013 mem_req  output  1  memory strobe, held until mem_ack.
REQ-014 mem_we  output  1  memory write.
REQ-015 mem_addr  output  32  word address, i.e. req_addr with bits [1:0] = 0.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_ack  input  1  memory done; mem_rdata valid this cycle.
REQ-019 mem_rdata  input  32  memory word.

Function
REQ-020 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-021 IDLE: req_ready=1; on req_valid, latch the request and go to WAIT, or go to RESP with error when REQ-027 or REQ-031 applies.
REQ-022 WAIT: mem_req=1 with stable address, data and enables; on mem_ack, capture data and go to RESP.
REQ-023 RESP: assert rsp_valid for exactly one cycle, then return to IDLE; req_ready=0 in WAIT and RESP.
REQ-024 Minimum latency from acceptance to rsp_valid shall be 2 cycles (mem_ack in the first WAIT cycle).
REQ-025 Store enables: SB -> 4'b0001 << addr[1:0]; SH -> 4'b0011 << addr[1:0]; SW -> 4'b1111.
REQ-026 Store data: mem_wdata = {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-027 Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) is handled per REQ-038/039.
REQ-028 Loads shall assert mem_be=4'b1111; rdata selects the lane by addr[1:0] and then sign-extends (B/H) or zero-extends (BU/HU).
REQ-029 A timeout counter shall clear on entering WAIT; if mem_ack is absent for TIMEOUT_CYCLES cycles, drop mem_req and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 mem_ack arriving in the same cycle that the counter reaches its limit shall count as success.
REQ-031 Illegal funct3 (011, 110, 111, or 100/101 with a store) shall produce rsp_err=1 with no memory access.
REQ-032 mem_ack outside WAIT shall be ignored.

Reset
REQ-033 On rst=0, immediately: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0.
REQ-034 Reset during WAIT shall abandon the access with no response, even if mem_ack later arrives.
REQ-035 The first request shall be accepted on the first rising edge with rst=1.

Configuration
REQ-036 The macro LSU_MISALIGN_TRAP_EN shall select misalignment behaviour.
REQ-037 Misaligned detection (REQ-027) shall be evaluated only on the accepted request.
REQ-038 Defined: a misaligned access goes to RESP with rsp_err=1 and no mem_req.
REQ-039 Undefined: offending low address bits are forced to 0 (H: bit 0; W: bits 1:0) and the access completes normally with rsp_err=0.

Structure
REQ-040 funct3 encodings, FSM state encodings and the TIMEOUT_CYCLES default shall live in the shared package rv_pkg.
REQ-041 Lane steering and extension shall be a combinational sub-module lsu_align, instantiated once for the store path and once for the load path.

Verification
REQ-042 SH, addr 0x102, wdata 0x0000BEEF, ack after 1 cycle -> mem_addr 0x100, mem_be 1100, mem_wdata 0xBEEFBEEF, rsp_valid 2 cycles after acceptance, rsp_err 0.
REQ-043 LB, addr 0x103, mem_rdata 0x80112233 -> rsp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-044 LH, addr 0x101: with LSU_MISALIGN_TRAP_EN -> rsp_err 1 and no mem_req; without it -> mem_addr 0x100, lower halfword returned.
REQ-045 LW with mem_ack never asserted -> rsp_err 1 exactly TIMEOUT_CYCLES+1 cycles after entering WAIT, and mem_req deasserts.
REQ-046 Reset asserted mid-WAIT, then mem_ack pulsed -> no rsp_valid, all outputs at reset values, and req_ready=1 after release.
REQ-047 Store with funct3=100 -> rsp_err 1 with no memory access; back-to-back req_valid -> second request accepted only after RESP.
